// File: rtl/tap_accum_sequencer_pkg.sv
// Shared definitions for the tap accumulator sequencer.
//   - FSM state encoding (IDLE / SUM / DONE)
//   - tap count and tap index width
//   - accumulator width derivation: an 8-tap sum needs log2(8) = 3 guard bits
package tap_accum_sequencer_pkg;

  localparam int NTAPS   = 8;
  localparam int IDX_W   = 3;
  localparam int GUARD_W = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUM  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int acc_width(input int dw);
    return dw + GUARD_W;
  endfunction

endpackage

// File: rtl/tap_accum_sequencer_tap_adder.sv
// tap_adder: combinational AW-bit two's complement ripple-carry adder.
// Ports:
//   a   in  AW  signed addend (running accumulator)
//   b   in  AW  signed addend (sign-extended tap)
//   sum out AW  signed a + b, wrapping; carry out discarded
module tap_adder #(
  parameter int AW = 10
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < AW; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/tap_accum_sequencer.sv
// tap_accum_sequencer: moving sum of the last 8 accepted signed samples.
// One shared adder walks the delay line one tap per cycle, so a sample
// takes 1 accept cycle + 8 SUM cycles + at least 1 DONE cycle.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   in_sample is valid
//   in_sample  in   DW  signed input sample
//   in_ready   out  1   high only in IDLE while rst is low
//   out_valid  out  1   out_data holds a finished 8-tap sum
//   out_data   out  AW  signed window sum, held until out_ready
//   out_ready  in   1   consumer takes out_data this cycle
module tap_accum_sequencer
  import tap_accum_sequencer_pkg::*;
#(
  parameter  int DW    = 7,
  parameter  int NTAPS = tap_accum_sequencer_pkg::NTAPS,
  localparam int AW    = acc_width(DW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_sample,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [AW-1:0] out_data,
  input  logic                 out_ready
);

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] x);
    return {{(AW-DW){x[DW-1]}}, x};
  endfunction

  state_t               state;
  logic [IDX_W-1:0]     idx_p1;
  logic signed [DW-1:0] tap_p0 [NTAPS];
  logic signed [AW-1:0] acc_p1;
  logic signed [AW-1:0] tap_ext;
  logic signed [AW-1:0] acc_sum;
  logic                 accept;
  logic                 last_tap;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign last_tap = (idx_p1 == IDX_W'(NTAPS - 1));

  // outputs are forced quiet while reset is held, whatever the state register shows
  assign out_valid = (state == ST_DONE) && !rst;
  assign out_data  = rst ? '0 : acc_p1;

  // stage p0 -> p1: 8:1 tap mux feeding the shared adder
  assign tap_ext = sext(tap_p0[idx_p1]);

  tap_adder #(.AW(AW)) u_tap_adder (
    .a   (acc_p1),
    .b   (tap_ext),
    .sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_p1 <= '0;
            state  <= ST_SUM;
          end
        end
        ST_SUM: begin
          idx_p1 <= idx_p1 + IDX_W'(1);
          if (last_tap) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // stage p0: delay line moves only on accept, so history survives between samples
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) tap_p0[k] <= '0;
    end else if (accept) begin
      tap_p0[0] <= in_sample;
      for (int k = 1; k < NTAPS; k++) tap_p0[k] <= tap_p0[k-1];
    end
  end

  // stage p1: accumulator, cleared on accept and fed by the adder during SUM
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (accept) begin
      acc_p1 <= '0;
    end else if (state == ST_SUM) begin
      acc_p1 <= acc_sum;
    end
  end

endmodule

// File: doc/tap_accum_sequencer.md
TAP_ACCUM_SEQUENCER -- requirements
Module: tap_accum_sequencer

Interface
REQ-001 Parameter DW, default 7: signed sample width in bits.
REQ-002 Parameter NTAPS, fixed at 8: tap count (delay-line depth); accumulator width AW = DW+3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  new sample present on in_sample.
REQ-006 in_sample  input  DW  signed input sample.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 out_valid  output  1  out_data holds a completed 8-tap sum.
REQ-009 out_data  output  AW  signed 8-tap window sum.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-011 Block computes a moving sum of the last 8 accepted samples using one shared adder, time-multiplexed over the taps (one tap per cycle).
REQ-012 FSM states: IDLE, SUM, DONE.
REQ-013 in_ready = 1 only in IDLE with rst low; 0 in SUM and DONE.
REQ-014 Accept = in_valid & in_ready; samples presented while in_ready = 0 are ignored, not queued.
REQ-015 On accept: delay line shifts (tap[k] <= tap[k-1], tap[0] <= in_sample, oldest dropped), accumulator <= 0, tap index <= 0, state -> SUM.
REQ-016 In SUM, each cycle: accumulator <= accumulator + sign-extended tap[index]; index increments; the add with index = 7 moves the state to DONE.
REQ-017 SUM lasts exactly 8 cycles; out_valid rises on the 8th rising edge after the accept edge.
REQ-018 In DONE: out_valid = 1; out_data = accumulator, held stable until handshake.
REQ-019 DONE with out_ready = 1: out_valid falls next edge; state -> IDLE; in_ready is high in the cycle after the handshake, not in the handshake cycle.
REQ-020 Maximum throughput: one sample per 10 cycles with in_valid and out_ready tied high.
REQ-021 Arithmetic: two's complement; the range for DW = 7 is -512..+504, which fits AW = 10; no saturation or overflow flag.
REQ-022 Delay-line contents persist across samples; only reset clears them.
REQ-023 Delay line changes only on accept, never during SUM or DONE.

Reset
REQ-024 While rst is high, on every edge: state <= IDLE, all taps <= 0, accumulator <= 0, index <= 0.
REQ-025 While rst is high, outputs are out_valid = 0, in_ready = 0, and out_data = 0.
REQ-026 Reset asserted in SUM or DONE abandons the operation; no out_valid is produced for that sample.
REQ-027 First edge with rst low: state is IDLE and in_ready = 1.

Structure
REQ-028 Shared package holds the state encoding (IDLE/SUM/DONE), NTAPS = 8, and the AW derivation.
REQ-029 One sub-module, tap_adder: combinational AW-bit signed ripple adder, instantiated exactly once.
REQ-030 Tap selection is an 8:1 mux indexed by the 3-bit tap index.

Verification
REQ-031 Reset, then one sample 5 -> out_data = 5, out_valid rises 8 edges after accept.
REQ-032 Eight consecutive samples of 63 -> the 8th result = 504; eight samples of -64 -> the 8th result = -512 (10'h200).
REQ-033 Samples 1..9 in order -> the 9th result = 44 (sum of 2..9; sample 1 dropped).
REQ-034 Hold out_ready low for 5 cycles in DONE while driving in_valid with sample 7.
- out_data stays stable and in_ready stays 0.
- Sample 7 is never absorbed.
REQ-035 Assert rst for 1 cycle on the 4th SUM cycle.
- out_valid never rises for that sample.
- Next sample 3 -> out_data = 3.
REQ-036 in_valid and out_ready tied high, constant sample 1 -> results 1,2,...,8,8.
- Accepts are spaced exactly 10 cycles apart.
